// File: rtl/data_reg_bank_stream_pkg.sv
// Shared types and helpers for the data_reg_bank_stream register bank.
package data_reg_bank_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        UNLOAD = 1'b1
    } state_t;

    // Pointer width for n slots; never below one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/data_reg_bank_stream_if.sv
// Stream-load / stream-unload handshake bundle of data_reg_bank_stream.
// Valid/ready: a beat transfers on every rising clk edge where valid & ready are both high;
// the source holds valid and data stable until that edge, and ready may depend on the source's strobes.
interface data_reg_bank_stream_if
    import data_reg_bank_pkg::*;
#(
    parameter int DATA_W = 32
);

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              load_done;
    logic              start_unload;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic              unload_done;
    logic              busy;
    state_t            unload_state;

    modport master (
        output in_valid,
        output in_data,
        output start_unload,
        output out_ready,
        input  in_ready,
        input  load_done,
        input  out_valid,
        input  out_data,
        input  unload_done,
        input  busy,
        input  unload_state
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  start_unload,
        input  out_ready,
        output in_ready,
        output load_done,
        output out_valid,
        output out_data,
        output unload_done,
        output busy,
        output unload_state
    );

endinterface

// File: rtl/data_reg_bank_stream_wrap_ptr_ctr.sv
// Modulo-MAX pointer: advances on inc, returns to 0 on clr or after slot MAX-1.
module wrap_ptr_ctr
    import data_reg_bank_pkg::*;
#(
    parameter  int MAX = 10,
    localparam int W   = clog2_min1(MAX)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] ptr,
    output logic         wrap
);

    // wrap marks the increment that leaves the last slot; a clr in the same cycle cancels it.
    assign wrap = inc & ~clr & (ptr == W'(MAX - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= wrap ? '0 : ptr + 1'b1;
        end
    end

endmodule

// File: rtl/data_reg_bank_stream.sv
// Parametrised register bank with addressed/parallel writes, stream load and FSM-driven stream unload.
// Optional synchronous clear port built when DATA_REG_BANK_CLEAR_EN is defined.
module data_reg_bank_stream
    import data_reg_bank_pkg::*;
#(
    parameter int NUM_REGS = 10,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = clog2_min1(NUM_REGS)
) (
    input  logic                       clk,
    input  logic                       rst,
`ifdef DATA_REG_BANK_CLEAR_EN
    input  logic                       clear,
`endif
    input  logic                       write_addr,
    input  logic [ADDR_W-1:0]          address,
    input  logic [DATA_W-1:0]          data_in,
    input  logic                       write_all,
    input  logic [NUM_REGS*DATA_W-1:0] par_in,
    output logic [NUM_REGS*DATA_W-1:0] regs_out,
    data_reg_bank_stream_if.slave      strm
);

    logic              clr;
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [ADDR_W-1:0] load_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              load_wrap;
    logic              rd_wrap;
    logic              accept;
    logic              out_fire;
    logic              rd_start;
    state_t            state;
    state_t            state_next;

`ifdef DATA_REG_BANK_CLEAR_EN
    assign clr = clear;
`else
    assign clr = 1'b0;
`endif

    assign strm.in_ready = ~write_addr & ~write_all & ~clr;
    assign accept        = strm.in_valid & strm.in_ready;

    assign strm.out_valid    = (state == UNLOAD);
    assign strm.busy         = (state == UNLOAD);
    assign strm.unload_state = state;
    assign strm.out_data     = regs[rd_ptr];
    assign out_fire          = strm.out_valid & strm.out_ready;
    assign rd_start          = (state == IDLE) & strm.start_unload;

    wrap_ptr_ctr #(.MAX(NUM_REGS)) u_load_ptr (
        .clk  (clk),
        .rst  (rst),
        .inc  (accept),
        .clr  (clr),
        .ptr  (load_ptr),
        .wrap (load_wrap)
    );

    wrap_ptr_ctr #(.MAX(NUM_REGS)) u_rd_ptr (
        .clk  (clk),
        .rst  (rst),
        .inc  (out_fire),
        .clr  (clr | rd_start),
        .ptr  (rd_ptr),
        .wrap (rd_wrap)
    );

    // One write source per edge; an out-of-range write_addr still blocks write_all and the stream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (write_addr) begin
            if (int'(address) < NUM_REGS) regs[address] <= data_in;
        end else if (write_all) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= par_in[i*DATA_W +: DATA_W];
        end else if (accept) begin
            regs[load_ptr] <= strm.in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            strm.load_done   <= 1'b0;
            strm.unload_done <= 1'b0;
        end else begin
            state            <= state_next;
            strm.load_done   <= load_wrap;
            strm.unload_done <= rd_wrap;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (strm.start_unload) state_next = UNLOAD;
            UNLOAD:  if (rd_wrap) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (clr) state_next = IDLE;
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_pack
        assign regs_out[g*DATA_W +: DATA_W] = regs[g];
    end

endmodule

// File: tb/tb_data_reg_bank_stream.sv
// Directed bench for data_reg_bank_stream: writes, stream load, stream unload, reset abort, optional clear.
module tb_data_reg_bank_stream;

    localparam int N  = 10;
    localparam int W  = 32;
    localparam int AW = 4;
    localparam int PW = N * W;

    logic          clk = 1'b0;
    logic          rst;
`ifdef DATA_REG_BANK_CLEAR_EN
    logic          clear;
`endif
    logic          write_addr;
    logic [AW-1:0] address;
    logic [W-1:0]  data_in;
    logic          write_all;
    logic [PW-1:0] par_in;
    logic [PW-1:0] regs_out;

    data_reg_bank_stream_if #(.DATA_W(W)) strm ();

    data_reg_bank_stream #(.NUM_REGS(N), .DATA_W(W)) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef DATA_REG_BANK_CLEAR_EN
        .clear      (clear),
`endif
        .write_addr (write_addr),
        .address    (address),
        .data_in    (data_in),
        .write_all  (write_all),
        .par_in     (par_in),
        .regs_out   (regs_out),
        .strm       (strm)
    );

    always #5 clk = ~clk;

    int           errors = 0;
    int           checks = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_w[N];
    logic [W-1:0] exp_word;
    int           k;
    int           cyc;
    int           done_cnt;
    logic         acc;

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] pack_exp();
        logic [PW-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = exp_w[i];
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
`ifdef DATA_REG_BANK_CLEAR_EN
        clear = 1'b0;
`endif
        write_addr        = 1'b0;
        address           = '0;
        data_in           = '0;
        write_all         = 1'b0;
        par_in            = '0;
        strm.in_valid     = 1'b0;
        strm.in_data      = '0;
        strm.start_unload = 1'b0;
        strm.out_ready    = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_regs", regs_out, '0);
        chk("rst_out_valid", strm.out_valid, 1'b0);
        chk("rst_busy", strm.busy, 1'b0);
        chk("rst_load_done", strm.load_done, 1'b0);
        chk("rst_unload_done", strm.unload_done, 1'b0);
        chk("rst_in_ready", strm.in_ready, 1'b1);
        rst = 1'b0;
        tick();

        // Addressed write to word 3
        write_addr = 1'b1;
        address    = 4'd3;
        data_in    = 32'hDEADBEEF;
        #1;
        chk("waddr_in_ready", strm.in_ready, 1'b0);
        tick();
        write_addr = 1'b0;
        for (int i = 0; i < N; i++) exp_w[i] = '0;
        exp_w[3] = 32'hDEADBEEF;
        chk("waddr_regs", regs_out, pack_exp());

        // Out-of-range address also blocks write_all
        write_addr = 1'b1;
        address    = 4'd12;
        data_in    = 32'h12345678;
        write_all  = 1'b1;
        par_in     = '1;
        tick();
        write_addr = 1'b0;
        write_all  = 1'b0;
        chk("oor_regs", regs_out, pack_exp());

        // Parallel write-all with word i = i+1
        for (int i = 0; i < N; i++) begin
            exp_w[i]          = W'(i + 1);
            par_in[i*W +: W]  = W'(i + 1);
        end
        write_all = 1'b1;
        tick();
        write_all = 1'b0;
        chk("wall_regs", regs_out, pack_exp());

        // Ten-beat stream load with valid held
        for (int b = 0; b < N; b++) begin
            strm.in_valid = 1'b1;
            strm.in_data  = 32'h100 + W'(b);
            #1;
            chk("load1_in_ready", strm.in_ready, 1'b1);
            tick();
            chk("load1_done", strm.load_done, (b == N - 1));
        end
        strm.in_valid = 1'b0;
        tick();
        chk("load1_done_drop", strm.load_done, 1'b0);
        for (int i = 0; i < N; i++) exp_w[i] = 32'h100 + W'(i);
        chk("load1_regs", regs_out, pack_exp());

        // Stream load interrupted by write_addr on the fifth cycle (beat 4 stalls)
        k        = 0;
        cyc      = 0;
        done_cnt = 0;
        while (k < N && cyc < 30) begin
            strm.in_valid = 1'b1;
            strm.in_data  = 32'h200 + W'(k);
            write_addr    = (cyc == 4);
            address       = 4'd7;
            data_in       = 32'hAAAA5555;
            acc           = (cyc != 4);
            #1;
            chk("load2_in_ready", strm.in_ready, acc);
            tick();
            if (acc) k++;
            if (strm.load_done) done_cnt++;
            cyc++;
        end
        strm.in_valid = 1'b0;
        write_addr    = 1'b0;
        tick();
        if (strm.load_done) done_cnt++;
        chk("load2_cycles", cyc, 11);
        chk("load2_done_count", done_cnt, 1);
        for (int i = 0; i < N; i++) exp_w[i] = 32'h200 + W'(i);
        chk("load2_regs", regs_out, pack_exp());

        // Unload with out_ready toggling; a second start_unload mid-stream is ignored
        for (int i = 0; i < N; i++) exp_q.push_back(32'h200 + W'(i));
        strm.start_unload = 1'b1;
        #1;
        chk("unload_pre_valid", strm.out_valid, 1'b0);
        tick();
        strm.start_unload = 1'b0;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 40) begin
            strm.out_ready    = (cyc % 2 == 0);
            strm.start_unload = (cyc == 3);
            #1;
            chk("unload_valid", strm.out_valid, 1'b1);
            chk("unload_busy", strm.busy, 1'b1);
            chk("unload_done_early", strm.unload_done, 1'b0);
            if (strm.out_ready) begin
                exp_word = exp_q.pop_front();
                chk("unload_data", strm.out_data, exp_word);
            end
            tick();
            cyc++;
        end
        strm.out_ready    = 1'b0;
        strm.start_unload = 1'b0;
        chk("unload_cycles", cyc, 19);
        chk("unload_done", strm.unload_done, 1'b1);
        chk("unload_end_busy", strm.busy, 1'b0);
        chk("unload_end_valid", strm.out_valid, 1'b0);
        tick();
        chk("unload_done_drop", strm.unload_done, 1'b0);

        // Reset while unloading at rd_ptr = 5
        for (int i = 0; i < N; i++) par_in[i*W +: W] = 32'h300 + W'(i);
        write_all = 1'b1;
        tick();
        write_all         = 1'b0;
        strm.start_unload = 1'b1;
        tick();
        strm.start_unload = 1'b0;
        strm.out_ready    = 1'b1;
        repeat (5) tick();
        chk("abort_data_5", strm.out_data, 32'h305);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_valid", strm.out_valid, 1'b0);
        chk("abort_busy", strm.busy, 1'b0);
        chk("abort_regs", regs_out, '0);
        tick();
        rst      = 1'b0;
        done_cnt = 0;
        repeat (3) begin
            tick();
            if (strm.unload_done) done_cnt++;
        end
        chk("abort_no_done", done_cnt, 0);
        chk("abort_idle_busy", strm.busy, 1'b0);
        strm.out_ready = 1'b0;

`ifdef DATA_REG_BANK_CLEAR_EN
        // Clear wins over write_addr and a stream beat, and rewinds both pointers
        for (int i = 0; i < N; i++) par_in[i*W +: W] = 32'h400 + W'(i);
        write_all = 1'b1;
        tick();
        write_all = 1'b0;
        for (int b = 0; b < 3; b++) begin
            strm.in_valid = 1'b1;
            strm.in_data  = 32'h500 + W'(b);
            tick();
        end
        strm.in_valid     = 1'b0;
        strm.start_unload = 1'b1;
        tick();
        strm.start_unload = 1'b0;
        strm.out_ready    = 1'b1;
        tick();
        tick();
        strm.out_ready = 1'b0;
        clear          = 1'b1;
        write_addr     = 1'b1;
        address        = 4'd2;
        data_in        = 32'h55;
        strm.in_valid  = 1'b1;
        strm.in_data   = 32'h66;
        #1;
        chk("clr_in_ready", strm.in_ready, 1'b0);
        tick();
        clear         = 1'b0;
        write_addr    = 1'b0;
        strm.in_valid = 1'b0;
        chk("clr_regs", regs_out, '0);
        chk("clr_busy", strm.busy, 1'b0);
        chk("clr_load_done", strm.load_done, 1'b0);
        chk("clr_unload_done", strm.unload_done, 1'b0);
        strm.in_valid = 1'b1;
        strm.in_data  = 32'h77;
        tick();
        strm.in_valid = 1'b0;
        for (int i = 0; i < N; i++) exp_w[i] = '0;
        exp_w[0] = 32'h77;
        chk("clr_load_ptr", regs_out, pack_exp());
        strm.start_unload = 1'b1;
        tick();
        strm.start_unload = 1'b0;
        chk("clr_rd_ptr", strm.out_data, 32'h77);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
